// File: rtl/uart_tx_prescaled.sv
// -----------------------------------------------------------------------------
// uart_tx_prescaled
//
// 8N1 UART transmitter (LSB first) with a built-in baud prescaler. The bit
// period is chosen by a 2-bit code that matches the board's baud display:
//   00 = 100000, 01 = 9600, 10 = 57600, 11 = 115200 baud.
// Divisors are CLK_FREQ/baud (truncated), fixed at elaboration.
//
// Ports:
//   clock         in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   tx_data       in   byte to send, sampled when a frame is accepted
//   tx_start      in   send request, accepted when the transmitter is free
//   baudrate_sel  in   baud code, sampled when a frame is accepted
//   tx_serial     out  serial line, idle high, registered
//   tx_busy       out  high from the accepting edge to the end of the stop bit
//   tx_done       out  one-cycle pulse at the end of each frame
// -----------------------------------------------------------------------------
module uart_tx_prescaled #(
    parameter int CLK_FREQ = 50000000,
    parameter int DIV_W    = 16
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic [1:0] baudrate_sel,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    // Last count value of a bit period for each baud code (DIV-1).
    localparam logic [DIV_W-1:0] LAST_00 = DIV_W'(CLK_FREQ / 100000 - 1);
    localparam logic [DIV_W-1:0] LAST_01 = DIV_W'(CLK_FREQ / 9600 - 1);
    localparam logic [DIV_W-1:0] LAST_10 = DIV_W'(CLK_FREQ / 57600 - 1);
    localparam logic [DIV_W-1:0] LAST_11 = DIV_W'(CLK_FREQ / 115200 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_period_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [1:0]       r_sel;
    logic             r_tx_serial;
    logic             r_tx_busy;
    logic             r_tx_done;

    logic [DIV_W-1:0] w_div_last;
    logic             w_period_end;
    logic             w_stop_end;
    logic             w_accept;

    always_comb begin
        w_div_last = LAST_00;
        case (r_sel)
            2'b00:   w_div_last = LAST_00;
            2'b01:   w_div_last = LAST_01;
            2'b10:   w_div_last = LAST_10;
            default: w_div_last = LAST_11;
        endcase
    end

    assign w_period_end = (r_period_cnt == w_div_last);
    assign w_stop_end   = (r_state == S_STOP) && w_period_end;

    // The edge that closes the stop bit counts as an idle edge: a request
    // present there starts the next frame at once, so back-to-back frames
    // have no idle gap and their tx_done pulses are exactly one frame apart.
    assign w_accept = tx_start && ((r_state == S_IDLE) || w_stop_end);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_period_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_sel        <= '0;
            r_tx_serial  <= 1'b1;
            r_tx_busy    <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (w_accept) begin
                r_shift      <= tx_data;
                r_sel        <= baudrate_sel;
                r_tx_serial  <= 1'b0;
                r_tx_busy    <= 1'b1;
                r_bit_cnt    <= '0;
                r_period_cnt <= '0;
                r_state      <= S_START;
                // Chained frame: the previous one still ends here.
                if (w_stop_end) begin
                    r_tx_done <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx_serial <= 1'b1;
                    end
                    S_START: begin
                        if (w_period_end) begin
                            r_period_cnt <= '0;
                            r_tx_serial  <= r_shift[0];
                            r_state      <= S_DATA;
                        end else begin
                            r_period_cnt <= r_period_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_period_end) begin
                            r_period_cnt <= '0;
                            if (r_bit_cnt == 3'd7) begin
                                r_tx_serial <= 1'b1;
                                r_state     <= S_STOP;
                            end else begin
                                // Bit 0 of the register is always on the line.
                                r_shift     <= r_shift >> 1;
                                r_tx_serial <= r_shift[1];
                                r_bit_cnt   <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_period_cnt <= r_period_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (w_period_end) begin
                            r_period_cnt <= '0;
                            r_tx_done    <= 1'b1;
                            r_tx_busy    <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_period_cnt <= r_period_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_serial = r_tx_serial;
    assign tx_busy   = r_tx_busy;
    assign tx_done   = r_tx_done;

endmodule
